mux3_rr_arbiter: RTL and testbench
==================================

// Module: mux3_rr_arbiter
// PURPOSE
//  Upstream select stage for a 3:1 datapath mux. Arbitrates three valid/ready
//  sources (A0..A2) round-robin and drives the registered mux select pair
//  (sl1,sl0). Captures the winning word into a single-entry output register
//  with a valid/ready handshake toward the consumer.
// PARAMETERS
//  DW      32   data width of each source and of out_data
// PORTS
//  clk        in   1   rising-edge clock, sole clock domain
//  rst        in   1   synchronous, active-high reset
//  a0_valid   in   1   source 0 has data
//  a0_data    in   DW  source 0 payload
//  a0_ready   out  1   source 0 word accepted this cycle
//  a1_valid   in   1   source 1 has data
//  a1_data    in   DW  source 1 payload
//  a1_ready   out  1   source 1 word accepted this cycle
//  a2_valid   in   1   source 2 has data
//  a2_data    in   DW  source 2 payload
//  a2_ready   out  1   source 2 word accepted this cycle
//  out_valid  out  1   out_data holds a word
//  out_data   out  DW  registered winning payload
//  out_ready  in   1   consumer accepts out_data this cycle
//  sl0        out  1   mux select low:  {sl1,sl0}=00 A0, 01 A1, 1x A2
//  sl1        out  1   mux select high (sl0 driven 0 whenever sl1=1)
// BEHAVIOUR
//  - Clock and reset: one clock (clk); rst is synchronous and active-high.
//  - Reset: out_valid=0, out_data=0, {sl1,sl0}=00, all aX_ready=0, last_grant=2
//    (A0 has top priority on the first arbitration).
//  - State: EMPTY (out_valid=0) / FULL (out_valid=1); 1-bit, derived from
//    out_valid.
//  - Load enable: ld = ~out_valid | out_ready.
//  - Arbitration is combinational each cycle. Priority order starts at
//    (last_grant+1) mod 3 and wraps: last_grant=0 -> 1,2,0; =1 -> 2,0,1;
//    =2 -> 0,1,2. Winner w = first valid source in that order.
//  - aX_ready = ld & (w==X) & aX_valid. At most one ready high per cycle.
//    A ready is never raised for a source whose valid is low.
//  - On an edge where ld and any valid: out_data<=aw_data, out_valid<=1,
//    {sl1,sl0}<=code(w), last_grant<=w. Latency is 1 clk from acceptance to
//    out_valid.
//  - On an edge where ld and no valid: out_valid<=0. out_data, sl and
//    last_grant hold.
//  - On an edge where ~ld (FULL & ~out_ready): everything holds; all ready=0.
//    out_data/sl are stable while out_valid & ~out_ready.
//  - Back-to-back: FULL & out_ready & a valid source -> drain and reload on the
//    same edge. Full throughput is 1 word/clk.
//  - Fairness: a continuously valid source waits at most 2 grants.
//  - Sources need not hold valid; dropping valid before ready is legal
//    (no grant occurs for it).
//  - Reset asserted mid-transfer discards the held word; no ready on that cycle.
//  - Unknown valid (X) is illegal. Assertions flag X on aX_valid/out_ready
//    outside reset.
// TESTING
//  1 Reset, then a0/a1/a2_valid=1 for 3 cycles, out_ready=1 -> grants A0,A1,A2
//    in order; sl={00,01,10}; out_data follows; 1 word/clk.
//  2 Only a1_valid=1 with a1_data=0x5A5A5A5A, out_ready=1 -> a1_ready every
//    cycle; out_data=0x5A5A5A5A; sl=01 from the cycle after the first grant.
//  3 FULL, out_ready=0 for 4 clk, all valids high -> every ready=0; out_data and
//    sl frozen; out_ready=1 -> next grant follows last_grant order.
//  4 a0_valid held 1 constantly, a2_valid raised at cycle 5 -> A2 granted within
//    2 grants; A0 never starved.
//  5 Assert rst while FULL with out_ready=0 -> next cycle out_valid=0, sl=00;
//    first grant after reset goes to A0 when all sources are valid.
//  6 All valids 0, out_ready=1 while FULL -> out_valid falls after 1 clk;
//    out_data and sl hold their last value.

Source files
------------

// File: rtl/mux3_rr_arbiter.sv
// Round-robin select stage for a 3:1 datapath mux: arbitrates three valid/ready
// sources, registers the winning word and drives the registered select pair.
module mux3_rr_arbiter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a0_valid,
    input  logic [DW-1:0] a0_data,
    output logic          a0_ready,
    input  logic          a1_valid,
    input  logic [DW-1:0] a1_data,
    output logic          a1_ready,
    input  logic          a2_valid,
    input  logic [DW-1:0] a2_data,
    output logic          a2_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          sl0,
    output logic          sl1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRC0 = 2'd0,
        SRC1 = 2'd1,
        SRC2 = 2'd2
    } src_t;

    state_t          state_q, state_d;
    src_t            last_grant_q, last_grant_d;
    src_t            win;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      sl_q, sl_d;
    logic [2:0]      valid_vec;
    logic            any_valid;
    logic            ld;
    logic            take;

    assign valid_vec = {a2_valid, a1_valid, a0_valid};
    assign any_valid = |valid_vec;
    assign out_valid = (state_q == FULL);
    assign ld        = ~out_valid | out_ready;
    // A reset cycle never accepts a word, so ready is suppressed while rst is high.
    assign take      = ld & any_valid & ~rst;

    // Priority rotates to start just after the previous winner.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win = SRC0;
        unique case (last_grant_q)
            SRC0: begin
                if      (a1_valid) win = SRC1;
                else if (a2_valid) win = SRC2;
                else               win = SRC0;
            end
            SRC1: begin
                if      (a2_valid) win = SRC2;
                else if (a0_valid) win = SRC0;
                else               win = SRC1;
            end
            default: begin
                if      (a0_valid) win = SRC0;
                else if (a1_valid) win = SRC1;
                else               win = SRC2;
            end
        endcase
    end

    assign a0_ready = take & (win == SRC0) & a0_valid;
    assign a1_ready = take & (win == SRC1) & a1_valid;
    assign a2_ready = take & (win == SRC2) & a2_valid;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        sl_d         = sl_q;
        if (ld) begin
            if (any_valid) begin
                state_d      = FULL;
                last_grant_d = win;
                unique case (win)
                    SRC0:    begin data_d = a0_data; sl_d = 2'b00; end
                    SRC1:    begin data_d = a1_data; sl_d = 2'b01; end
                    default: begin data_d = a2_data; sl_d = 2'b10; end
                endcase
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q      <= EMPTY;
            last_grant_q <= SRC2;
            data_q       <= '0;
            sl_q         <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            sl_q         <= sl_d;
        end
    end

    assign out_data = data_q;
    assign sl1      = sl_q[1];
    assign sl0      = sl_q[0];

    a_no_x_ctrl: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({a0_valid, a1_valid, a2_valid, out_ready}))
        else $error("unknown value on valid/out_ready");

    a_ready_onehot: assert property (@(posedge clk)
        $onehot0({a2_ready, a1_ready, a0_ready}))
        else $error("more than one ready asserted");

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed-vector bench for mux3_rr_arbiter: hand-computed ready, select,
// data and valid expectations across grant rotation, stall, drain and reset.
module tb_mux3_rr_arbiter;

    localparam int DW = 32;
    localparam logic [DW-1:0] D0 = 32'h1111_0000;
    localparam logic [DW-1:0] D1 = 32'h5A5A_5A5A;
    localparam logic [DW-1:0] D2 = 32'h3333_2222;

    logic          clk = 1'b0;
    logic          rst;
    logic          a0_valid, a1_valid, a2_valid;
    logic [DW-1:0] a0_data, a1_data, a2_data;
    logic          a0_ready, a1_ready, a2_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          sl0, sl1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux3_rr_arbiter #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .a0_valid(a0_valid), .a0_data(a0_data), .a0_ready(a0_ready),
        .a1_valid(a1_valid), .a1_data(a1_data), .a1_ready(a1_ready),
        .a2_valid(a2_valid), .a2_data(a2_data), .a2_ready(a2_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sl0(sl0), .sl1(sl1)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input logic [2:0] v);
        {a2_valid, a1_valid, a0_valid} = v;
        #1;
    endtask

    // Readies for the upcoming edge plus registered outputs from the last edge.
    task automatic expect_all(input string tag, input logic [2:0] rdy, input logic ov,
                              input logic [DW-1:0] d, input logic [1:0] sl);
        check({tag, ".ready"}, {29'd0, a2_ready, a1_ready, a0_ready}, {29'd0, rdy});
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ov});
        if (ov) check({tag, ".data"}, out_data, d);
        check({tag, ".sl"}, {30'd0, sl1, sl0}, {30'd0, sl});
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        a0_data = D0; a1_data = D1; a2_data = D2;
        set_valid(3'b000);
        cyc(); cyc();
        expect_all("rst", 3'b000, 1'b0, '0, 2'b00);
        check("rst.data", out_data, '0);

        // Rotation with all sources valid, one word per clock.
        rst = 1'b0; out_ready = 1'b1;
        set_valid(3'b111);
        expect_all("rr0", 3'b001, 1'b0, '0, 2'b00);
        cyc(); expect_all("rr1", 3'b010, 1'b1, D0, 2'b00);
        cyc(); expect_all("rr2", 3'b100, 1'b1, D1, 2'b01);
        cyc(); expect_all("rr3", 3'b001, 1'b1, D2, 2'b10);

        // Consumer stall: nothing accepted, outputs frozen.
        out_ready = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            expect_all("stall", 3'b000, 1'b1, D2, 2'b10);
            cyc();
        end
        expect_all("stall_end", 3'b000, 1'b1, D2, 2'b10);
        out_ready = 1'b1; #1;
        expect_all("resume", 3'b001, 1'b1, D2, 2'b10);
        cyc(); expect_all("resume1", 3'b010, 1'b1, D0, 2'b00);

        // Single source A1 streams every cycle.
        set_valid(3'b010);
        expect_all("a1_0", 3'b010, 1'b1, D0, 2'b00);
        cyc(); expect_all("a1_1", 3'b010, 1'b1, D1, 2'b01);
        cyc(); expect_all("a1_2", 3'b010, 1'b1, D1, 2'b01);

        // A0 constant, A2 joins later and is served without starving A0.
        set_valid(3'b001);
        for (int i = 0; i < 4; i++) begin
            expect_all("a0_only.ready", 3'b001, 1'b1, (i == 0) ? D1 : D0, (i == 0) ? 2'b01 : 2'b00);
            cyc();
        end
        set_valid(3'b101);
        expect_all("fair0", 3'b100, 1'b1, D0, 2'b00);
        cyc(); expect_all("fair1", 3'b001, 1'b1, D2, 2'b10);
        cyc(); expect_all("fair2", 3'b100, 1'b1, D0, 2'b00);
        cyc(); expect_all("fair3", 3'b001, 1'b1, D2, 2'b10);
        out_ready = 1'b0; #1;
        expect_all("fair_hold", 3'b000, 1'b1, D2, 2'b10);

        // Drain: no valid sources while FULL.
        out_ready = 1'b1;
        set_valid(3'b000);
        expect_all("drain0", 3'b000, 1'b1, D2, 2'b10);
        cyc(); expect_all("drain1", 3'b000, 1'b0, '0, 2'b10);
        check("drain1.data_hold", out_data, D2);

        // Reset while FULL discards the word; A0 wins first afterwards.
        set_valid(3'b010);
        expect_all("pre_rst", 3'b010, 1'b0, '0, 2'b10);
        cyc(); expect_all("pre_rst1", 3'b010, 1'b1, D1, 2'b01);
        out_ready = 1'b0; #1;
        cyc(); expect_all("pre_rst2", 3'b000, 1'b1, D1, 2'b01);
        rst = 1'b1; out_ready = 1'b1;
        set_valid(3'b111);
        check("rst_mid.ready", {29'd0, a2_ready, a1_ready, a0_ready}, 32'd0);
        cyc(); rst = 1'b0; #1;
        check("rst_mid.data", out_data, '0);
        expect_all("post_rst", 3'b001, 1'b0, '0, 2'b00);
        cyc(); expect_all("post_rst1", 3'b010, 1'b1, D0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
